popcount_pipe: RTL and testbench

Pipelined, parametrised population-count engine with a valid/ready stream interface and an optional per-packet accumulate mode. Each accepted WIDTH-bit word is reduced by a registered adder tree, one tree level per stage. The result is either emitted per word or summed across a packet up to `in_last`. It is the sequential, streaming successor to the combinational 16-bit popcount benchmark and feeds count-reduction kernels in the PIM benchmark suite.

---
 rtl/popcount_pipe.sv | 100 ++++++++++
 tb/tb_popcount_pipe.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/popcount_pipe.sv
// popcount_pipe: pipelined popcount with one registered adder-tree level per stage,
// valid/ready streaming and an optional saturating per-packet accumulator.
module popcount_pipe #(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_accum,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_count,
  output logic                 out_ovf
);
  localparam int L = $clog2(WIDTH);
  logic w_en;
  assign w_en     = !out_valid || out_ready;
  assign in_ready = w_en;
  // Level 0 is the raw word viewed as WIDTH one-bit sums; level k holds WIDTH>>k sums of k+1 bits.
  genvar k;
  for (k = 0; k <= L; k++) begin : g_st
    logic [(WIDTH>>k)*(k+1)-1:0] w_sum;
    logic                        w_v;
    logic                        w_acc;
    logic                        w_last;
    if (k == 0) begin : g_in
      assign w_sum  = in_data;
      assign w_v    = in_valid;
      assign w_acc  = in_accum;
      assign w_last = in_last;
    end else begin : g_reg
      logic [(WIDTH>>k)*(k+1)-1:0] r_sum;
      logic                        r_v;
      logic                        r_acc;
      logic                        r_last;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_sum  <= '0;
          r_v    <= 1'b0;
          r_acc  <= 1'b0;
          r_last <= 1'b0;
        end else if (w_en) begin
          for (int j = 0; j < (WIDTH >> k); j++)
            r_sum[j*(k+1) +: k+1] <= {1'b0, g_st[k-1].w_sum[2*j*k +: k]}
                                   + {1'b0, g_st[k-1].w_sum[(2*j+1)*k +: k]};
          r_v    <= g_st[k-1].w_v;
          r_acc  <= g_st[k-1].w_acc;
          r_last <= g_st[k-1].w_last;
        end
      end
      assign w_sum  = r_sum;
      assign w_v    = r_v;
      assign w_acc  = r_acc;
      assign w_last = r_last;
    end
  end
  logic [L:0]           w_c;
  logic [ACC_WIDTH:0]   w_tot;
  logic [ACC_WIDTH-1:0] w_sat;
  logic                 w_sovf;
  logic [ACC_WIDTH-1:0] r_acc;
  logic                 r_acc_ovf;
  logic [ACC_WIDTH-1:0] r_out_count;
  logic                 r_out_ovf;
  logic                 r_out_valid;
  assign w_c    = g_st[L].w_sum;
  assign w_tot  = {1'b0, r_acc} + (ACC_WIDTH+1)'(w_c);
  assign w_sovf = w_tot[ACC_WIDTH];
  assign w_sat  = w_sovf ? '1 : w_tot[ACC_WIDTH-1:0];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= '0;
      r_acc_ovf   <= 1'b0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_en) begin
      r_out_valid <= g_st[L].w_v && (!g_st[L].w_acc || g_st[L].w_last);
      if (g_st[L].w_v && !g_st[L].w_acc) begin
        r_out_count <= ACC_WIDTH'(w_c);
        r_out_ovf   <= 1'b0;
      end else if (g_st[L].w_v && g_st[L].w_last) begin
        r_out_count <= w_sat;
        r_out_ovf   <= r_acc_ovf || w_sovf;
        r_acc       <= '0;
        r_acc_ovf   <= 1'b0;
      end else if (g_st[L].w_v) begin
        r_acc       <= w_sat;
        r_acc_ovf   <= r_acc_ovf || w_sovf;
      end
    end
  end
  assign out_count = r_out_count;
  assign out_ovf   = r_out_ovf;
  assign out_valid = r_out_valid;
endmodule

// File: tb/tb_popcount_pipe.sv
// tb_popcount_pipe: directed and random stimulus against a packet-level reference model
// (WIDTH=16, ACC_WIDTH=5 so saturation is reachable).
module tb_popcount_pipe;
  localparam int W    = 16;
  localparam int AW   = 5;
  localparam int MAXC = (1 << AW) - 1;
  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_accum;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_count;
  logic          out_ovf;
  typedef struct {int cnt; int ovf; int acyc;} exp_t;
  exp_t q[$];
  int   macc = 0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  logic lat_on = 1'b0;
  popcount_pipe #(.WIDTH(W), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_accum(in_accum), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_count(out_count), .out_ovf(out_ovf)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  // Scoreboard: an unbounded packet total, saturated only when the packet closes.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (q.size() == 0) check("spurious_out", 1, 0);
        else begin
          check("count", out_count, q[0].cnt);
          check("ovf", out_ovf, q[0].ovf);
          if (out_ready) begin
            if (lat_on) check("latency", cyc - q[0].acyc, 5);
            void'(q.pop_front());
          end
        end
      end
      if (in_valid && in_ready) begin
        if (!in_accum) q.push_back('{$countones(in_data), 0, cyc});
        else begin
          macc += $countones(in_data);
          if (in_last) begin
            q.push_back('{(macc > MAXC) ? MAXC : macc, (macc > MAXC) ? 1 : 0, cyc});
            macc = 0;
          end
        end
      end
    end
  end
  task automatic send(input logic [W-1:0] d, input logic a, input logic l);
    bit ok = 0;
    in_valid = 1'b1; in_data = d; in_accum = a; in_last = l;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) check("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask
  task automatic drain();
    for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
    check("drain", q.size(), 0);
    @(posedge clk); #1;
  endtask
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_count", out_count, 0);
    check("rst_ovf", out_ovf, 0);
    q.delete();
    macc = 0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_ready", in_ready, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_accum = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    #2;
    check("init_valid", out_valid, 0);
    check("init_count", out_count, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("init_ready", in_ready, 1);
    lat_on = 1'b1;
    send(16'hFFFF, 0, 0); send(16'h0000, 0, 0); send(16'hA5A5, 0, 0);
    drain();
    send(16'hFFFF, 1, 0); send(16'h00FF, 1, 0); send(16'h0001, 1, 1);
    drain();
    send(16'hFFFF, 1, 0); send(16'hFFFF, 1, 0); send(16'hFFFF, 1, 1); send(16'h0003, 1, 1);
    drain();
    send(16'h000F, 1, 0); send(16'h0007, 0, 0); send(16'h0001, 1, 1);
    drain();
    lat_on = 1'b0;
    send(16'h0001, 0, 0); send(16'h0003, 0, 0); send(16'h0007, 0, 0); send(16'h000F, 0, 0);
    for (int i = 0; i < 20 && !out_valid; i++) begin @(posedge clk); #1; end
    check("stall_setup", out_valid, 1);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h00FF; in_accum = 1'b0; in_last = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();
    send(16'hFFFF, 0, 0); send(16'h00FF, 1, 0);
    for (int i = 0; i < 20 && !out_valid; i++) begin @(posedge clk); #1; end
    check("rst_setup", out_valid, 1);
    do_reset();
    lat_on = 1'b1;
    send(16'h0003, 1, 1);
    drain();
    lat_on = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (i == 200) do_reset();
      in_valid  = ($urandom % 4) != 0;
      in_data   = ($urandom % 2) ? W'($urandom) : W'($urandom & $urandom & $urandom);
      in_accum  = $urandom % 2;
      in_last   = ($urandom % 3) == 0;
      out_ready = ($urandom % 4) != 0;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    drain();
    repeat (10) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
